// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider, one quotient bit per clock.
// A single N-bit subtract/compare datapath walks the dividend MSB-first.
// For a start accepted at edge k, valid is high in the cycle after edge k+N.
// For a zero divisor, valid is high in the cycle after edge k+1.
// Optional build macro: DIV_SEQ_SIGNED_EN selects two's-complement operands.
// In that build, magnitudes are divided and signs are applied on the final edge.
module div_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         valid,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic [N-1:0]  rem_reg;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  dvsr_reg;
    logic          zero_reg;
    logic          busy_reg;
    logic          valid_reg;
    logic [N-1:0]  quotient_reg;
    logic [N-1:0]  remainder_reg;
    logic          div_zero_reg;

    // Datapath signals for one restoring step.
    logic [N:0]    t_word;
    logic          t_ge;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  q_next;

    // Operands as seen by the iteration, and final results after any sign fix-up.
    logic [N-1:0]  dvnd_mag;
    logic [N-1:0]  dvsr_mag;
    logic [N-1:0]  quot_fix;
    logic [N-1:0]  rem_fix;

    // One restoring step.
    // The partial remainder shifts left and takes in the next dividend bit.
    // The comparison is N+1 bits wide, so a remainder with its MSB set cannot overflow.
    always_comb begin
        t_word   = {rem_reg, q_reg[N-1]};
        t_ge     = (t_word >= {1'b0, dvsr_reg});
        rem_next = t_ge ? N'(t_word - {1'b0, dvsr_reg}) : t_word[N-1:0];
        q_next   = {q_reg[N-2:0], t_ge};
    end

`ifdef DIV_SEQ_SIGNED_EN
    logic q_neg_reg;
    logic r_neg_reg;

    // Divide magnitudes.
    // The quotient is negated when the operand signs differ.
    // The remainder follows the sign of the dividend.
    always_comb begin
        dvnd_mag = dividend[N-1] ? -dividend : dividend;
        dvsr_mag = divisor[N-1]  ? -divisor  : divisor;
        quot_fix = q_neg_reg ? -q_next   : q_next;
        rem_fix  = r_neg_reg ? -rem_next : rem_next;
    end

    // Capture the result signs alongside the operands on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
        end else if (start && !busy_reg) begin
            q_neg_reg <= dividend[N-1] ^ divisor[N-1];
            r_neg_reg <= dividend[N-1];
        end
    end
`else
    // Unsigned build: operands and results pass straight through.
    always_comb begin
        dvnd_mag = dividend;
        dvsr_mag = divisor;
        quot_fix = q_next;
        rem_fix  = rem_next;
    end
`endif

    // Control FSM with registered handshake and result outputs.
    // A zero divisor is given a single dummy BUSY cycle with a count of 1.
    // During that cycle q_reg holds the raw dividend, which becomes the remainder.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            count_reg     <= '0;
            rem_reg       <= '0;
            q_reg         <= '0;
            dvsr_reg      <= '0;
            zero_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg <= S_BUSY;
                        busy_reg  <= 1'b1;
                        rem_reg   <= '0;
                        dvsr_reg  <= dvsr_mag;
                        if (divisor == '0) begin
                            zero_reg  <= 1'b1;
                            count_reg <= CW'(1);
                            q_reg     <= dividend;
                        end else begin
                            zero_reg  <= 1'b0;
                            count_reg <= CW'(N);
                            q_reg     <= dvnd_mag;
                        end
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    count_reg <= count_reg - CW'(1);
                    rem_reg   <= rem_next;
                    q_reg     <= q_next;
                    if (count_reg == CW'(1)) begin
                        state_reg    <= S_DONE;
                        busy_reg     <= 1'b0;
                        valid_reg    <= 1'b1;
                        div_zero_reg <= zero_reg;
                        if (zero_reg) begin
                            quotient_reg  <= '1;
                            remainder_reg <= q_reg;
                        end else begin
                            quotient_reg  <= quot_fix;
                            remainder_reg <= rem_fix;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign valid     = valid_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed checks for div_seq at N=32.
// Covers reset, latency, extreme operands, divide by zero, and start while busy.
// Also covers reset mid-operation, back-to-back starts, and signed or unsigned wrap cases.
module tb_div_seq;

    localparam int N     = 32;
    localparam int LIMIT = 200;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         valid;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_zero;

    int checks = 0;
    int passes = 0;

    div_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Present a request for one edge.
    // The task returns at the negedge just after the accepting edge.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 'x;
        divisor  = 'x;
    endtask

    // Count edges after the accepting edge until valid appears.
    // Also count the samples in which busy was high.
    task automatic wait_valid(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!valid && lat < LIMIT) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || div_zero !== 1'b0)
            $display("FAIL reset_flags busy=%b valid=%b div_zero=%b required 0/0/0", busy, valid, div_zero);
        else passes++;
        checks++;
        if (quotient !== '0 || remainder !== '0)
            $display("FAIL reset_results q=%h r=%h required 0/0", quotient, remainder);
        else passes++;
        rst = 1'b0;
        @(negedge clk);
        $display("reset released: busy=%b valid=%b", busy, valid);
    endtask

    task automatic test_basic();
        int lat, bcnt;
        issue(32'd100, 32'd7);
        wait_valid(lat, bcnt);
        $display("op 100/7: lat=%0d busy_cycles=%0d q=%0d r=%0d dz=%b", lat, bcnt, quotient, remainder, div_zero);
        checks++;
        if (lat !== 32) $display("FAIL basic_latency got %0d required 32", lat); else passes++;
        checks++;
        if (bcnt !== 32) $display("FAIL basic_busy_cycles got %0d required 32", bcnt); else passes++;
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_zero !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_result q=%0d r=%0d dz=%b busy=%b required 14/2/0/0", quotient, remainder, div_zero, busy);
        else passes++;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2)
            $display("FAIL basic_pulse_hold valid=%b q=%0d r=%0d required 0/14/2", valid, quotient, remainder);
        else passes++;
    endtask

    task automatic test_extremes();
        int lat, bcnt;
        issue(32'hFFFF_FFFF, 32'd1);
        wait_valid(lat, bcnt);
        $display("op ffffffff/1: lat=%0d q=%h r=%h", lat, quotient, remainder);
        checks++;
        if (lat !== 32 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd0)
            $display("FAIL max_by_one lat=%0d q=%h r=%h required 32/ffffffff/0", lat, quotient, remainder);
        else passes++;
        @(negedge clk);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(lat, bcnt);
        $display("op ffffffff/ffffffff: lat=%0d q=%h r=%h", lat, quotient, remainder);
        checks++;
        if (quotient !== 32'd1 || remainder !== 32'd0)
            $display("FAIL max_by_max q=%h r=%h required 1/0", quotient, remainder);
        else passes++;
        @(negedge clk);
        issue(32'h1234_5678, 32'h0000_0100);
        wait_valid(lat, bcnt);
        $display("op 12345678/100: lat=%0d q=%h r=%h", lat, quotient, remainder);
        checks++;
        if (quotient !== 32'h0012_3456 || remainder !== 32'h0000_0078)
            $display("FAIL shift_pattern q=%h r=%h required 00123456/00000078", quotient, remainder);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        issue(32'd5, 32'd0);
        wait_valid(lat, bcnt);
        $display("op 5/0: lat=%0d q=%h r=%h dz=%b", lat, quotient, remainder, div_zero);
        checks++;
        if (lat !== 1) $display("FAIL div_zero_latency got %0d required 1", lat); else passes++;
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_zero !== 1'b1)
            $display("FAIL div_zero_result q=%h r=%h dz=%b required ffffffff/5/1", quotient, remainder, div_zero);
        else passes++;
        @(negedge clk);
        issue(32'd9, 32'd3);
        wait_valid(lat, bcnt);
        $display("op 9/3: lat=%0d q=%0d r=%0d dz=%b", lat, quotient, remainder, div_zero);
        checks++;
        if (quotient !== 32'd3 || remainder !== 32'd0 || div_zero !== 1'b0)
            $display("FAIL div_zero_clear q=%0d r=%0d dz=%b required 3/0/0", quotient, remainder, div_zero);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        issue(32'd200, 32'd9);
        wait_valid(lat, bcnt);
        $display("op 200/9: lat=%0d q=%0d r=%0d", lat, quotient, remainder);
        checks++;
        if (quotient !== 32'd22 || remainder !== 32'd2)
            $display("FAIL b2b_first q=%0d r=%0d required 22/2", quotient, remainder);
        else passes++;
        // Issue the next request while valid is high, so the FSM accepts it from DONE.
        issue(32'd77, 32'd7);
        wait_valid(lat, bcnt);
        $display("op 77/7 (from done): lat=%0d q=%0d r=%0d", lat, quotient, remainder);
        checks++;
        if (lat !== 32 || quotient !== 32'd11 || remainder !== 32'd0)
            $display("FAIL b2b_second lat=%0d q=%0d r=%0d required 32/11/0", lat, quotient, remainder);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int pulses, first;
        pulses = 0;
        first  = -1;
        issue(32'd3, 32'd5);
        for (int j = 0; j < 46; j++) begin
            if (valid) begin
                pulses++;
                if (first < 0) first = j;
            end
            @(negedge clk);
            if (j == 3) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd5;
            end else if (j == 4) begin
                start    = 1'b0;
                dividend = 'x;
                divisor  = 'x;
            end
        end
        $display("op 3/5 with ignored 50/5: pulses=%0d first=%0d q=%0d r=%0d", pulses, first, quotient, remainder);
        checks++;
        if (pulses !== 1 || first !== 32)
            $display("FAIL busy_ignore_pulse pulses=%0d at %0d required 1 at 32", pulses, first);
        else passes++;
        checks++;
        if (quotient !== 32'd0 || remainder !== 32'd3)
            $display("FAIL busy_ignore_result q=%0d r=%0d required 0/3", quotient, remainder);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, late;
        issue(32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("reset at busy cycle 10: busy=%b valid=%b q=%0d r=%0d", busy, valid, quotient, remainder);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_zero !== 1'b0)
            $display("FAIL reset_mid busy=%b valid=%b q=%0d r=%0d dz=%b required all 0", busy, valid, quotient, remainder, div_zero);
        else passes++;
        rst = 1'b0;
        late = 0;
        for (int j = 0; j < 40; j++) begin
            if (valid || busy) late++;
            @(negedge clk);
        end
        checks++;
        if (late !== 0) $display("FAIL reset_mid_no_valid activity samples=%0d required 0", late); else passes++;
        issue(32'd9, 32'd3);
        wait_valid(lat, bcnt);
        $display("op 9/3 after reset: lat=%0d q=%0d r=%0d", lat, quotient, remainder);
        checks++;
        if (lat !== 32 || quotient !== 32'd3 || remainder !== 32'd0)
            $display("FAIL reset_mid_recover lat=%0d q=%0d r=%0d required 32/3/0", lat, quotient, remainder);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_sign_mode();
        int lat, bcnt;
`ifdef DIV_SEQ_SIGNED_EN
        issue(32'hFFFF_FFF9, 32'd2);
        wait_valid(lat, bcnt);
        $display("signed -7/2: lat=%0d q=%h r=%h", lat, quotient, remainder);
        checks++;
        if (lat !== 32 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF)
            $display("FAIL signed_neg_dividend lat=%0d q=%h r=%h required 32/fffffffd/ffffffff", lat, quotient, remainder);
        else passes++;
        @(negedge clk);
        issue(32'd7, 32'hFFFF_FFFE);
        wait_valid(lat, bcnt);
        $display("signed 7/-2: q=%h r=%h", quotient, remainder);
        checks++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'd1)
            $display("FAIL signed_neg_divisor q=%h r=%h required fffffffd/1", quotient, remainder);
        else passes++;
        @(negedge clk);
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        wait_valid(lat, bcnt);
        $display("signed min/-1: q=%h r=%h", quotient, remainder);
        checks++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'd0)
            $display("FAIL signed_min_by_m1 q=%h r=%h required 80000000/0", quotient, remainder);
        else passes++;
        @(negedge clk);
        issue(32'hFFFF_FFF9, 32'd0);
        wait_valid(lat, bcnt);
        $display("signed -7/0: lat=%0d q=%h r=%h dz=%b", lat, quotient, remainder, div_zero);
        checks++;
        if (lat !== 1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'hFFFF_FFF9 || div_zero !== 1'b1)
            $display("FAIL signed_div_zero lat=%0d q=%h r=%h dz=%b required 1/ffffffff/fffffff9/1", lat, quotient, remainder, div_zero);
        else passes++;
        @(negedge clk);
`else
        issue(32'hFFFF_FFF9, 32'd2);
        wait_valid(lat, bcnt);
        $display("unsigned fffffff9/2: lat=%0d q=%h r=%h", lat, quotient, remainder);
        checks++;
        if (quotient !== 32'h7FFF_FFFC || remainder !== 32'd1)
            $display("FAIL unsigned_high_dividend q=%h r=%h required 7ffffffc/1", quotient, remainder);
        else passes++;
        @(negedge clk);
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        wait_valid(lat, bcnt);
        $display("unsigned 80000000/ffffffff: q=%h r=%h", quotient, remainder);
        checks++;
        if (quotient !== 32'd0 || remainder !== 32'h8000_0000)
            $display("FAIL unsigned_small_quotient q=%h r=%h required 0/80000000", quotient, remainder);
        else passes++;
        @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid();
        test_sign_mode();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
